instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/instr_fetch.sv | 94 +++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared ISA constants: instruction width, opcode field location and opcode encodings.
package mips_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LW   = 4'h7,
    OP_SW   = 4'h8,
    OP_BEQ  = 4'h9,
    OP_BNE  = 4'hA,
    OP_J    = 4'hB,
    OP_JAL  = 4'hC,
    OP_JR   = 4'hD,
    OP_LUI  = 4'hE,
    OP_NOP  = 4'hF
  } opcode_e;

  function automatic opcode_e opcode_of(input logic [INSTR_W-1:0] word);
    return opcode_e'(word[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {instr, pc} entries; flush clears it in one cycle.
// Zero-latency head; caller must never push when full or pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         vld_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign vld_o      = (count_q != '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && !flush_i && count_q == FULL_CNT));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && count_q == '0));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC into a 1-cycle imem, responses buffered for the decoder (IFETCH_SKID_EN: 2-entry buffer, else 1).
// Read-to-valid 2 cycles; reads throttle so buffer plus in-flight never exceed DEPTH while the decoder stalls.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

`ifdef IFETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int ENT_W = INSTR_W + ADDR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              pop, push, rd_en;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_vld;
  logic [ENT_W-1:0]  buf_head;
  logic [CNT_W:0]    occ;

  assign pop  = instr_valid & instr_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push = inflight_q & ~redirect_valid;

  // Slots committed after this cycle if no new read were issued.
  assign occ   = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign rd_en = ~rst & ~redirect_valid & (occ < DEPTH_C);

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = rd_en;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (rd_en) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fetch_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .push_dat_i ({imem_rdata, req_pc_q}),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .head_dat_o (buf_head),
    .count_o    (buf_count),
    .vld_o      (buf_vld)
  );

  assign instr_valid = buf_vld & ~rst;
  assign instr       = instr_valid ? buf_head[ENT_W-1:ADDR_W] : '0;
  assign instr_pc    = instr_valid ? buf_head[ADDR_W-1:0]     : '0;
  assign imem_rd_en  = rd_en;
  assign imem_addr   = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: scoreboard of expected fetch addresses plus directed latency/throughput checks.
module tb_instr_fetch;

`ifdef IFETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_tail = '0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The architectural stream restarts at the reset/redirect target and counts up modulo 256.
  task automatic reload(input logic [7:0] p);
    exp_q.delete();
    exp_tail = p;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) reload(8'h00);
    else if (redirect_valid) reload(redirect_pc);
    while (exp_q.size() < 32) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 8'd1;
    end
    #1;
  endtask

  // Monitor: pops the scoreboard on every transfer, checks hold-while-stalled.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_instr = '0;
  logic [7:0]  prev_pc = '0;
  logic [7:0]  mon_e;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", instr_valid, 0);
      check("rst_rden", imem_rd_en, 0);
      prev_stall = 1'b0;
    end else begin
      if (redirect_valid) check("redir_rden", imem_rd_en, 0);
      if (prev_stall && instr_valid) begin
        check("hold_instr", instr, prev_instr);
        check("hold_pc", instr_pc, prev_pc);
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got pc %0h expected no transfer", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_pc", instr_pc, mon_e);
          check("sb_instr", instr, mem[mon_e]);
        end
      end
      prev_stall = instr_valid && !instr_ready;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  int  r;
  int  stall_left;
  bit  was_rst;
  bit  found;
  bit  exp_v;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    rst = 1'b1;
    instr_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_addr", imem_addr, 0);
    tick();

    // Reset release: read at 0 now, first word valid two cycles later.
    rst = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    check("rel_rden", imem_rd_en, 1);
    check("rel_addr", imem_addr, 0);
    check("rel_valid0", instr_valid, 0);
    tick();
    @(negedge clk);
    check("rel_valid1", instr_valid, 0);
    tick();
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      exp_v = (DEPTH == 2) || (k % 2 == 0);
      check("tput_valid", instr_valid, exp_v);
      if (exp_v) begin
        check("tput_pc", instr_pc, (DEPTH == 2) ? (k - 2) : ((k - 2) / 2));
        if (k == 2) check("first_instr", instr, 32'h1000);
      end
      tick();
    end

    // Decoder stall: fetch must throttle, then resume without loss.
    instr_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check("stall_rden", imem_rd_en, 0);
        check("stall_valid", instr_valid, 1);
      end
      tick();
    end
    instr_ready = 1'b1;
    repeat (20) tick();

    // Redirect with a read in flight.
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      if (imem_rd_en) found = 1'b1;
      else tick();
    end
    check("redir_found_read", found, 1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    check("redir_t_rden", imem_rd_en, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_t1_rden", imem_rd_en, 1);
    check("redir_t1_addr", imem_addr, 8'h40);
    check("redir_t1_valid", instr_valid, 0);
    tick();
    @(negedge clk);
    check("redir_t2_valid", instr_valid, 0);
    tick();
    @(negedge clk);
    check("redir_t3_valid", instr_valid, 1);
    check("redir_t3_pc", instr_pc, 8'h40);
    check("redir_t3_instr", instr, 16'h1040);
    tick();

    // Back-to-back redirects: the last target wins.
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    tick();
    redirect_pc = 8'h20;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 8 && !found; w++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        check("dbl_redir_pc", instr_pc, 8'h20);
      end
      tick();
    end
    check("dbl_redir_seen", found, 1);

    // PC wrap 0xFF -> 0x00.
    redirect_valid = 1'b1;
    redirect_pc = 8'hFD;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (instr_valid && instr_ready && instr_pc == 8'hFF) found = 1'b1;
      tick();
    end
    check("wrap_seen_ff", found, 1);
    found = 1'b0;
    for (int w = 0; w < 6 && !found; w++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        found = 1'b1;
        check("wrap_pc_00", instr_pc, 8'h00);
      end
      tick();
    end
    check("wrap_seen_00", found, 1);

    // Random traffic: ready jitter, stalls, redirects, mid-stream resets.
    stall_left = 0;
    was_rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 99));
      redirect_valid = 1'b0;
      rst = 1'b0;
      instr_ready = ($urandom_range(0, 9) < 7);
      if (stall_left > 0) begin
        instr_ready = 1'b0;
        stall_left--;
      end
      if (was_rst) begin
        @(negedge clk);
        check("post_rst_rden", imem_rd_en, 1);
        check("post_rst_addr", imem_addr, 8'h00);
        was_rst = 1'b0;
      end else if (r < 1) begin
        rst = 1'b1;
        was_rst = 1'b1;
      end else if (r < 4) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? 8'hFC : 8'($urandom_range(0, 255));
      end else if (r < 6) begin
        stall_left = 6;
      end
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
